// File: rtl/slave_port_if.sv
// Serial system-bus lines between one master port and one slave port.
// All lines are single-bit; the master drives the header and write data, the slave returns read data.
interface slave_port_if;
    logic select;
    logic write_en;
    logic read_en;
    logic master_valid;
    logic master_ready;
    logic rx_address;
    logic rx_burst_num;
    logic rx_data;
    logic tx_data;
    logic slave_valid;
    logic slave_ready;
    logic done;

    modport master (
        output select, write_en, read_en, master_valid, master_ready,
               rx_address, rx_burst_num, rx_data,
        input  tx_data, slave_valid, slave_ready, done
    );

    modport slave (
        input  select, write_en, read_en, master_valid, master_ready,
               rx_address, rx_burst_num, rx_data,
        output tx_data, slave_valid, slave_ready, done
    );
endinterface

// File: rtl/slave_port.sv
// Serial bus responder: deserialises address/burst header and write data, performs
// burst transfers on a synchronous memory port and serialises read words back, LSB first.
module slave_port #(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                clk,
    input  logic                reset,
    slave_port_if.slave         bus,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata
);
    localparam int HDR   = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
    localparam int MAXC  = (HDR > DATA_LEN) ? HDR : DATA_LEN;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, HEADER, WR_RX, WR_MEM, RD_MEM, RD_LOAD, RD_TX, DONE
    } state_t;

    state_t                 state_reg;
    logic                   op_write_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [ADDR_LEN-1:0]    addr_reg;
    logic [BURST_LEN-1:0]   burst_reg;
    logic [BURST_LEN-1:0]   beat_reg;
    logic [DATA_LEN-1:0]    word_reg;
    logic [DATA_LEN-1:0]    shift_reg;

    logic [ADDR_LEN-1:0]    addr_hit;
    logic [BURST_LEN-1:0]   burst_hit;
    logic [DATA_LEN-1:0]    word_hit;
    logic                   start;
    logic                   last_beat;

    // One-hot bit-position selects driven by the shared bit counter
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_LEN; gi++) begin : g_addr_hit
            assign addr_hit[gi] = (cnt_reg == CNT_W'(gi));
        end
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_burst_hit
            assign burst_hit[gi] = (cnt_reg == CNT_W'(gi));
        end
        for (gi = 0; gi < DATA_LEN; gi++) begin : g_word_hit
            assign word_hit[gi] = (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    assign start = bus.select & bus.master_valid & (bus.write_en ^ bus.read_en);
    // A burst value of zero still moves one word
    assign last_beat = (burst_reg == '0) || (beat_reg == burst_reg - BURST_LEN'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_write_reg <= 1'b0;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            burst_reg    <= '0;
            beat_reg     <= '0;
            word_reg     <= '0;
            shift_reg    <= '0;
        end else if (state_reg != IDLE && !bus.select) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    op_write_reg <= bus.write_en;
                    cnt_reg      <= '0;
                    beat_reg     <= '0;
                    state_reg    <= HEADER;
                end
                HEADER: begin
                    addr_reg  <= (addr_reg & ~addr_hit) | (addr_hit & {ADDR_LEN{bus.rx_address}});
                    burst_reg <= (burst_reg & ~burst_hit) | (burst_hit & {BURST_LEN{bus.rx_burst_num}});
                    if (cnt_reg == HDR_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= op_write_reg ? WR_RX : RD_MEM;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WR_RX: if (bus.master_valid) begin
                    word_reg <= (word_reg & ~word_hit) | (word_hit & {DATA_LEN{bus.rx_data}});
                    if (cnt_reg == DATA_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= WR_MEM;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WR_MEM: begin
                    addr_reg  <= addr_reg + 1'b1;
                    beat_reg  <= beat_reg + 1'b1;
                    state_reg <= last_beat ? DONE : WR_RX;
                end
                RD_MEM:  state_reg <= RD_LOAD;
                RD_LOAD: begin
                    shift_reg <= mem_rdata;
                    state_reg <= RD_TX;
                end
                RD_TX: if (bus.master_ready) begin
                    shift_reg <= shift_reg >> 1;
                    if (cnt_reg == DATA_LAST) begin
                        cnt_reg   <= '0;
                        addr_reg  <= addr_reg + 1'b1;
                        beat_reg  <= beat_reg + 1'b1;
                        state_reg <= last_beat ? DONE : RD_MEM;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes are gated by select so an aborting cycle never touches memory
    assign bus.slave_ready = (state_reg == IDLE) || (state_reg == WR_RX);
    assign bus.slave_valid = (state_reg == RD_TX);
    assign bus.tx_data     = (state_reg == RD_TX) & shift_reg[0];
    assign bus.done        = (state_reg == DONE);
    assign mem_we          = (state_reg == WR_MEM) & bus.select;
    assign mem_re          = (state_reg == RD_MEM) & bus.select;
    assign mem_addr        = addr_reg;
    assign mem_wdata       = word_reg;
endmodule

// File: tb/tb_slave_port.sv
// Self-checking bench for slave_port: vector table of bus transactions plus hand-written
// abort / reset / illegal-start sequences, with queue scoreboards for writes, read bits and done.
module tb_slave_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_we;
    logic        mem_re;

    slave_port_if bus();

    slave_port #(.ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous memory with registered read
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_evt(string name, int act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h want nothing (cycle %0d)", name, act, cyc);
    endfunction

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t  wq[$];
    logic bq[$];
    int   dq[$];
    int   re_count = 0;
    wr_t  e_w;
    int   e_d;
    logic prev_sv = 1'b0, prev_mr = 1'b0, prev_tx = 1'b0;

    // Output monitor on the falling edge
    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) fail_evt("unexpected_we", int'(mem_addr));
            else begin
                e_w = wq.pop_front();
                check("we_addr", int'(mem_addr), int'(e_w.addr));
                check("we_data", int'(mem_wdata), int'(e_w.data));
                check("we_cycle", cyc, e_w.cyc);
            end
        end
        if (mem_re) re_count++;
        if (bus.slave_valid && prev_sv && !prev_mr)
            check("tx_hold", int'(bus.tx_data), int'(prev_tx));
        if (bus.slave_valid && bus.master_ready) begin
            if (bq.size() == 0) fail_evt("unexpected_bit", int'(bus.tx_data));
            else check("tx_bit", int'(bus.tx_data), int'(bq.pop_front()));
        end
        if (bus.done) begin
            if (dq.size() == 0) fail_evt("unexpected_done", cyc);
            else begin
                e_d = dq.pop_front();
                check("done_cycle", cyc, e_d);
            end
        end
        prev_sv <= bus.slave_valid;
        prev_mr <= bus.master_ready;
        prev_tx <= bus.tx_data;
    end

    typedef struct {
        bit             wr;
        logic [11:0]    addr;
        logic [11:0]    burst;
        logic [3:0][7:0] data;
        int             stall_beat;
        int             stall_bit;
        bit             toggle;
        int             abort_beat;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.select = 0; bus.write_en = 0; bus.read_en = 0; bus.master_valid = 0;
        bus.master_ready = 0; bus.rx_address = 0; bus.rx_burst_num = 0; bus.rx_data = 0;
    endtask

    // Start strobe at T0 then 12 header cycles; enables driven opposite during the header
    task automatic send_header(input vec_t v);
        step();
        bus.select = 1; bus.master_valid = 1;
        bus.write_en = v.wr; bus.read_en = !v.wr;
        for (int k = 0; k < 12; k++) begin
            step();
            bus.master_valid = 0;
            bus.write_en = !v.wr; bus.read_en = v.wr;
            bus.rx_address = v.addr[k];
            bus.rx_burst_num = v.burst[k];
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int beats;
        int acc;
        int off;
        int c;
        beats = (v.burst == 0) ? 1 : int'(v.burst);
        $display("txn %0d %s addr=%03h burst=%0d", id, v.wr ? "write" : "read", v.addr, v.burst);
        send_header(v);
        bus.write_en = 0; bus.read_en = 0;
        if (v.wr) begin
            for (int b = 0; b < beats; b++) begin
                for (int i = 0; i < 8; i++) begin
                    step();
                    if (b == v.stall_beat && i == v.stall_bit) begin
                        for (int s = 0; s < 2; s++) begin
                            bus.master_valid = 0;
                            bus.rx_data = ~v.data[b][i];
                            step();
                        end
                    end
                    bus.master_valid = 1;
                    bus.rx_data = v.data[b][i];
                end
                c = cyc;
                if (b == v.abort_beat) begin
                    step();
                    bus.master_valid = 0;
                    bus.select = 0;
                    step();
                    check("abort_idle_ready", int'(bus.slave_ready), 1);
                    check("abort_no_valid", int'(bus.slave_valid), 0);
                    step();
                    check("abort_no_done", dq.size(), 0);
                    bus_idle();
                    return;
                end
                wq.push_back('{12'(v.addr + 12'(b)), v.data[b], c + 1});
                if (b == beats - 1) dq.push_back(c + 2);
                step();
                bus.master_valid = 0;
                check("wrmem_ready", int'(bus.slave_ready), 0);
            end
        end else begin
            for (int b = 0; b < beats; b++) begin
                step();
                bus.master_ready = 0;
                check("rdmem_valid", int'(bus.slave_valid), 0);
                for (int i = 0; i < 8; i++) bq.push_back(v.data[b][i]);
                step();
                acc = 0;
                off = 0;
                while (acc < 8) begin
                    step();
                    bus.master_ready = v.toggle ? off[0] : 1'b1;
                    check("rdtx_valid", int'(bus.slave_valid), 1);
                    if (bus.master_ready) acc++;
                    off++;
                end
                if (b == beats - 1) dq.push_back(cyc + 1);
            end
        end
        step();
        bus.master_ready = 0;
        check("done_ready", int'(bus.slave_ready), 0);
        step();
        bus.select = 0;
        check("end_idle_ready", int'(bus.slave_ready), 1);
        check("done_seen", dq.size(), 0);
        check("writes_drained", wq.size(), 0);
        check("bits_drained", bq.size(), 0);
    endtask

    initial begin
        int rc0;
        vec_t v;
        vecs[0] = '{1'b1, 12'h0A5, 12'd1, 32'h0000003C, -1, 0, 1'b0, -1};
        vecs[1] = '{1'b1, 12'hFFE, 12'd3, 32'h00332211,  1, 4, 1'b0, -1};
        vecs[2] = '{1'b1, 12'h100, 12'd2, 32'h0000C35A, -1, 0, 1'b0, -1};
        vecs[3] = '{1'b1, 12'h2F0, 12'd2, 32'h00007796, -1, 0, 1'b0, -1};
        vecs[4] = '{1'b1, 12'h010, 12'd0, 32'h000000A7, -1, 0, 1'b0, -1};
        vecs[5] = '{1'b0, 12'h100, 12'd2, 32'h0000C35A, -1, 0, 1'b1, -1};
        vecs[6] = '{1'b0, 12'h2F0, 12'd0, 32'h00000096, -1, 0, 1'b0, -1};
        vecs[7] = '{1'b0, 12'hFFE, 12'd3, 32'h00332211, -1, 0, 1'b0, -1};
        vecs[8] = '{1'b0, 12'h0A5, 12'd1, 32'h0000003C, -1, 0, 1'b1, -1};

        bus_idle();
        #2;
        check("rst_ready", int'(bus.slave_ready), 1);
        check("rst_valid", int'(bus.slave_valid), 0);
        check("rst_tx", int'(bus.tx_data), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_re", int'(mem_re), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        step();
        step();
        reset = 0;

        for (int n = 0; n < 9; n++) run_vec(n, vecs[n]);

        // Illegal start: both enables, then neither
        $display("txn illegal start");
        rc0 = re_count;
        step();
        bus.select = 1; bus.master_valid = 1; bus.write_en = 1; bus.read_en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) begin bus.write_en = 0; bus.read_en = 0; end
            bus.rx_address = i[0];
            check("illegal_idle_ready", int'(bus.slave_ready), 1);
        end
        bus_idle();
        step();
        check("illegal_no_re", re_count, rc0);

        // Abort: select drops in the second beat's memory-write cycle
        v = '{1'b1, 12'h300, 12'd2, 32'h00005544, -1, 0, 1'b0, 1};
        run_vec(9, v);

        // Reset while transmitting a read word
        $display("txn reset during read");
        v = '{1'b0, 12'h100, 12'd2, 32'h0000C35A, -1, 0, 1'b0, -1};
        send_header(v);
        bus.write_en = 0; bus.read_en = 0;
        step();
        step();
        step();
        bus.master_ready = 0;
        check("pre_rst_valid", int'(bus.slave_valid), 1);
        #2 reset = 1;
        #1;
        check("midrst_valid", int'(bus.slave_valid), 0);
        check("midrst_tx", int'(bus.tx_data), 0);
        check("midrst_ready", int'(bus.slave_ready), 1);
        check("midrst_re", int'(mem_re), 0);
        check("midrst_addr", int'(mem_addr), 0);
        check("midrst_done", int'(bus.done), 0);
        bus_idle();
        step();
        step();
        reset = 0;
        step();
        check("postrst_ready", int'(bus.slave_ready), 1);

        // Readback of the beat completed before the abort
        v = '{1'b0, 12'h300, 12'd2, 32'h00000044, -1, 0, 1'b0, -1};
        v.burst = 12'd1;
        run_vec(10, v);

        step();
        step();
        check("final_writes_empty", wq.size(), 0);
        check("final_done_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
